// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM arbiter: FSM states and master indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam int M_FETCH = 0;
  localparam int M_LSU   = 1;

endpackage

// File: rtl/arb_pick.sv
// Two-input grant picker; the arbitration policy lives here so the FSM stays policy-agnostic.
// RAM_ARBITER_ROUND_ROBIN_EN selects round-robin, otherwise fixed priority m1 > m0.
module arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  assign valid = |eligible;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  assign pick = (eligible == 2'b11) ? ~last : eligible[M_LSU];
`else
  // last carries no weight under fixed priority; it is masked off here
  assign pick = eligible[M_LSU] | (eligible[M_FETCH] & last & 1'b0);
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (m0) and load/store (m1).
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority m1 > m0.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdata,
  output logic            ram_en,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wmask,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int MW = DW / 8;

  state_t          state, state_n;
  logic            ram_en_n;
  logic [AW-1:0]   ram_addr_n;
  logic [DW-1:0]   ram_wdata_n;
  logic [MW-1:0]   ram_wmask_n;
  logic            cur, cur_n;
  logic [1:0]      ack, ack_n;
  logic [1:0]      req, eligible;
  logic            valid, pick;
  logic            last;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic            last_n;
`else
  assign last = 1'b1;
`endif

  assign req = {m1_req, m0_req};

  // In RESP the acked master still holds req this cycle, so it is masked out
  always_comb begin
    eligible = 2'b00;
    case (state)
      ST_IDLE: eligible = req;
      ST_RESP: eligible = req & ~(2'b01 << cur);
      default: eligible = 2'b00;
    endcase
  end

  arb_pick u_pick (
    .eligible (eligible),
    .last     (last),
    .valid    (valid),
    .pick     (pick)
  );

  always_comb begin
    state_n     = state;
    ram_en_n    = 1'b0;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    ram_wmask_n = ram_wmask;
    cur_n       = cur;
    ack_n       = 2'b00;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    last_n      = last;
`endif
    case (state)
      ST_ISSUE: begin
        ram_wmask_n = '0;
        ack_n[cur]  = 1'b1;
        state_n     = ST_RESP;
      end
      default: begin
        if (valid) begin
          ram_en_n = 1'b1;
          cur_n    = pick;
          state_n  = ST_ISSUE;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
          last_n   = pick;
`endif
          if (pick) begin
            ram_addr_n  = m1_addr;
            ram_wdata_n = m1_wdata;
            ram_wmask_n = m1_wmask;
          end else begin
            ram_addr_n  = m0_addr;
            ram_wdata_n = '0;
            ram_wmask_n = '0;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wmask <= '0;
      cur       <= 1'b0;
      ack       <= 2'b00;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      last      <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      ram_en    <= ram_en_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      ram_wmask <= ram_wmask_n;
      cur       <= cur_n;
      ack       <= ack_n;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      last      <= last_n;
`endif
    end
  end

  // RAM read data arrives in the RESP cycle, alongside the registered ack
  assign m0_ack   = ack[M_FETCH];
  assign m1_ack   = ack[M_LSU];
  assign m0_rdata = ack[M_FETCH] ? ram_rdata : '0;
  assign m1_rdata = ack[M_LSU]   ? ram_rdata : '0;

endmodule
